wb_commit_fifo: RTL and testbench
=================================

Name: wb_commit_fifo

Overview:
- Retirement-side consumer for the dual-issue datapath's two writeback slots (ds1, ds2).
- Accepts up to two committed writebacks per cycle, in program order, and buffers them.
- Presents them one per cycle on a valid/ready read port for trace checking, scoreboard comparison or a debug UART.
- Converts the 2-wide writeback stream into a 1-wide ordered commit stream.

Parameters:
- DWIDTH, 32, writeback data width (matches `DWIDTH).
- PC_WIDTH, 32, program counter width (matches `PC_WIDTH).
- AWIDTH, 5, destination register index width.
- DEPTH, 8, entry count; power of two, >= 4.
- FILTER_R0, 1, when 1, writebacks with rd == 0 are discarded at input.

Ports:
- d_clk  input  1  clock; all state updates on rising edge.
- d_rst  input  1  reset; synchronous, active-high.
- ds1_i_valid  input  1  slot 1 writeback valid (older instruction).
- ds1_i_rd  input  AWIDTH  slot 1 destination register.
- ds1_i_data  input  DWIDTH  slot 1 writeback data.
- ds1_i_pc  input  PC_WIDTH  slot 1 instruction PC.
- ds2_i_valid  input  1  slot 2 writeback valid (younger instruction).
- ds2_i_rd  input  AWIDTH  slot 2 destination register.
- ds2_i_data  input  DWIDTH  slot 2 writeback data.
- ds2_i_pc  input  PC_WIDTH  slot 2 instruction PC.
- f_o_wb_ready  output  1  high when free entries >= 2.
- f_o_valid  output  1  head entry available.
- f_i_ready  input  1  consumer accepts head this cycle.
- f_o_rd  output  AWIDTH  head rd.
- f_o_data  output  DWIDTH  head data.
- f_o_pc  output  PC_WIDTH  head PC.
- f_o_count  output  $clog2(DEPTH)+1  occupied entries.
- f_o_overflow  output  1  sticky; a writeback was dropped.

Behaviour:
Reset:
- While d_rst=1 at a rising edge: wr_ptr=0, rd_ptr=0, count=0, overflow=0.
- Entry contents are don't-care after reset.
- Reset mid-operation discards all buffered entries; there is no drain.
- Reset has priority over simultaneous push and pop.

Outputs:
- f_o_valid = (count != 0).
- f_o_rd/f_o_data/f_o_pc = mem[rd_ptr] when valid, else all zero; the bench checks zero when empty.
- f_o_wb_ready = (DEPTH - count) >= 2. It is computed from registered count only; a same-cycle pop does not raise it.

Push qualification:
- Slot k is effective when dsk_i_valid=1 and not (FILTER_R0=1 and dsk_i_rd=0).

Push:
- Only performed when f_o_wb_ready=1.
- Both slots effective: ds1 written at wr_ptr, ds2 at wr_ptr+1; wr_ptr += 2.
- Exactly one effective (either slot): written at wr_ptr; wr_ptr += 1.
- ds2-only is legal.

Drop:
- Any effective slot while f_o_wb_ready=0: the whole cycle's writebacks are dropped, no partial acceptance.
- overflow is set to 1 and held until reset.
- Filtered rd=0 writebacks never set overflow.

Pop:
- Occurs when f_o_valid=1 and f_i_ready=1; rd_ptr += 1.
- Pop when empty is ignored.

Pointers and latency:
- Pointers wrap modulo DEPTH (index DEPTH-1 -> 0).
- No bypass: an entry written in cycle N is first visible at the head in cycle N+1, even if the FIFO was empty.

Count:
- count_next = count + pushes(0..2) - pop(0..1), evaluated against pre-edge state.
- count never exceeds DEPTH and never goes below 0.
- Order invariant: pop order = ds1-before-ds2 within a cycle, and earlier cycles before later.

Test Plan:
1. Hold d_rst=1 for 2 cycles, no traffic -> f_o_valid=0, f_o_count=0, f_o_wb_ready=1, f_o_overflow=0, f_o_rd/data/pc=0.
2. Single-cycle dual push ds1{rd=3,data=5,pc=0}, ds2{rd=4,data=7,pc=4}, f_i_ready=0 -> next cycle count=2, head rd=3 data=5 pc=0. Pop -> head rd=4 data=7 pc=4. Pop -> f_o_valid=0, count=0.
3. FILTER_R0=1: ds1{rd=0,data=9}, ds2{rd=9,data=0x11} -> count=1, head rd=9 data=0x11, overflow=0. Repeat with ds1 only, rd=0 -> count unchanged.
4. DEPTH=8, no pops: 3 dual pushes -> count=6, wb_ready=1. 4th dual push -> count=8, wb_ready=0. 5th push {rd=7} -> count stays 8, overflow=1. Drain 8 entries -> overflow still 1 until d_rst.
5. Wrap and concurrency: push data 1..10 (rd=1..10) as mixed single/dual pushes, popping one per cycle whenever valid, including cycles with 2 pushes plus 1 pop at count=3 (-> count=4). Read sequence must be exactly 1..10 across the 7->0 pointer wrap.
6. count=5, assert d_rst=1 while ds1_i_valid=1 and f_i_ready=1 -> next cycle count=0, f_o_valid=0, overflow=0. A push after reset release appears at head with count=1.

Source files
------------

// File: rtl/wb_commit_fifo.sv
// wb_commit_fifo: collapses the two writeback slots (ds1 older, ds2 younger)
// into a single in-order commit stream. Either slot can be pushed each cycle,
// and one entry is read out per cycle through a valid/ready port.
module wb_commit_fifo #(
    parameter int DWIDTH    = 32,
    parameter int PC_WIDTH  = 32,
    parameter int AWIDTH    = 5,
    parameter int DEPTH     = 8,
    parameter int FILTER_R0 = 1
) (
    input  logic                     d_clk,
    input  logic                     d_rst,
    input  logic                     ds1_i_valid,
    input  logic [AWIDTH-1:0]        ds1_i_rd,
    input  logic [DWIDTH-1:0]        ds1_i_data,
    input  logic [PC_WIDTH-1:0]      ds1_i_pc,
    input  logic                     ds2_i_valid,
    input  logic [AWIDTH-1:0]        ds2_i_rd,
    input  logic [DWIDTH-1:0]        ds2_i_data,
    input  logic [PC_WIDTH-1:0]      ds2_i_pc,
    output logic                     f_o_wb_ready,
    output logic                     f_o_valid,
    input  logic                     f_i_ready,
    output logic [AWIDTH-1:0]        f_o_rd,
    output logic [DWIDTH-1:0]        f_o_data,
    output logic [PC_WIDTH-1:0]      f_o_pc,
    output logic [$clog2(DEPTH):0]   f_o_count,
    output logic                     f_o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AWIDTH-1:0]   mem_rd   [DEPTH];
    logic [DWIDTH-1:0]   mem_data [DEPTH];
    logic [PC_WIDTH-1:0] mem_pc   [DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;

    logic          eff1;
    logic          eff2;
    logic          push1;
    logic          push2;
    logic [1:0]    n_push;
    logic          pop;
    logic          drop;
    logic [PW-1:0] wr_idx2;

    // Qualify slots, gate pushes on space, and decide the pop for this cycle.
    always_comb begin
        eff1    = ds1_i_valid && !((FILTER_R0 != 0) && (ds1_i_rd == '0));
        eff2    = ds2_i_valid && !((FILTER_R0 != 0) && (ds2_i_rd == '0));
        // Space check uses registered count only, so a pop never frees room in the same cycle.
        f_o_wb_ready = (count <= CW'(DEPTH - 2));
        push1   = eff1 && f_o_wb_ready;
        push2   = eff2 && f_o_wb_ready;
        n_push  = {1'b0, push1} + {1'b0, push2};
        drop    = (eff1 || eff2) && !f_o_wb_ready;
        f_o_valid = (count != '0);
        pop     = f_o_valid && f_i_ready;
        // ds2 lands behind ds1 when both push, otherwise takes the write slot itself.
        wr_idx2 = push1 ? (wr_ptr + PW'(1)) : wr_ptr;
    end

    // Pointer, occupancy and sticky overflow state.
    always_ff @(posedge d_clk) begin
        if (d_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(n_push) - CW'(pop);
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Entry storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge d_clk) begin
        if (push1) begin
            mem_rd[wr_ptr]   <= ds1_i_rd;
            mem_data[wr_ptr] <= ds1_i_data;
            mem_pc[wr_ptr]   <= ds1_i_pc;
        end
        if (push2) begin
            mem_rd[wr_idx2]   <= ds2_i_rd;
            mem_data[wr_idx2] <= ds2_i_data;
            mem_pc[wr_idx2]   <= ds2_i_pc;
        end
    end

    // Head presentation, forced to zero while empty so idle output is clean.
    always_comb begin
        f_o_rd       = '0;
        f_o_data     = '0;
        f_o_pc       = '0;
        if (f_o_valid) begin
            f_o_rd   = mem_rd[rd_ptr];
            f_o_data = mem_data[rd_ptr];
            f_o_pc   = mem_pc[rd_ptr];
        end
        f_o_count    = count;
        f_o_overflow = overflow;
    end

endmodule

// File: tb/tb_wb_commit_fifo.sv
// Directed bench for wb_commit_fifo with DEPTH=8 and rd=0 filtering on.
module tb_wb_commit_fifo;

    localparam int DWIDTH   = 32;
    localparam int PC_WIDTH = 32;
    localparam int AWIDTH   = 5;
    localparam int DEPTH    = 8;

    logic                  d_clk = 1'b0;
    logic                  d_rst;
    logic                  ds1_i_valid;
    logic [AWIDTH-1:0]     ds1_i_rd;
    logic [DWIDTH-1:0]     ds1_i_data;
    logic [PC_WIDTH-1:0]   ds1_i_pc;
    logic                  ds2_i_valid;
    logic [AWIDTH-1:0]     ds2_i_rd;
    logic [DWIDTH-1:0]     ds2_i_data;
    logic [PC_WIDTH-1:0]   ds2_i_pc;
    logic                  f_o_wb_ready;
    logic                  f_o_valid;
    logic                  f_i_ready;
    logic [AWIDTH-1:0]     f_o_rd;
    logic [DWIDTH-1:0]     f_o_data;
    logic [PC_WIDTH-1:0]   f_o_pc;
    logic [$clog2(DEPTH):0] f_o_count;
    logic                  f_o_overflow;

    int n_chk = 0;
    int n_bad = 0;

    wb_commit_fifo #(
        .DWIDTH(DWIDTH), .PC_WIDTH(PC_WIDTH), .AWIDTH(AWIDTH),
        .DEPTH(DEPTH), .FILTER_R0(1)
    ) dut (
        .d_clk(d_clk), .d_rst(d_rst),
        .ds1_i_valid(ds1_i_valid), .ds1_i_rd(ds1_i_rd), .ds1_i_data(ds1_i_data), .ds1_i_pc(ds1_i_pc),
        .ds2_i_valid(ds2_i_valid), .ds2_i_rd(ds2_i_rd), .ds2_i_data(ds2_i_data), .ds2_i_pc(ds2_i_pc),
        .f_o_wb_ready(f_o_wb_ready), .f_o_valid(f_o_valid), .f_i_ready(f_i_ready),
        .f_o_rd(f_o_rd), .f_o_data(f_o_data), .f_o_pc(f_o_pc),
        .f_o_count(f_o_count), .f_o_overflow(f_o_overflow)
    );

    always #5 d_clk = ~d_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge d_clk);
        #1;
    endtask

    task automatic set_wb(input logic v1, input int rd1, input int d1, input int pc1,
                          input logic v2, input int rd2, input int d2, input int pc2);
        ds1_i_valid = v1; ds1_i_rd = AWIDTH'(rd1); ds1_i_data = DWIDTH'(d1); ds1_i_pc = PC_WIDTH'(pc1);
        ds2_i_valid = v2; ds2_i_rd = AWIDTH'(rd2); ds2_i_data = DWIDTH'(d2); ds2_i_pc = PC_WIDTH'(pc2);
    endtask

    task automatic clr_wb();
        set_wb(1'b0, 0, 0, 0, 1'b0, 0, 0, 0);
    endtask

    // Wrap/concurrency schedule: pushes per cycle and expected count after each edge.
    int sched_push [11] = '{2, 1, 2, 2, 1, 2, 0, 0, 0, 0, 0};
    int sched_cnt  [11] = '{2, 2, 3, 4, 4, 5, 4, 3, 2, 1, 0};

    initial begin
        int next_wr;
        int next_rd;
        int pre_cnt;

        d_rst = 1'b1;
        f_i_ready = 1'b0;
        clr_wb();

        // Reset state
        step();
        step();
        chk("rst_valid", 64'(f_o_valid), 64'd0);
        chk("rst_count", 64'(f_o_count), 64'd0);
        chk("rst_wbrdy", 64'(f_o_wb_ready), 64'd1);
        chk("rst_ovf", 64'(f_o_overflow), 64'd0);
        chk("rst_rd", 64'(f_o_rd), 64'd0);
        chk("rst_data", 64'(f_o_data), 64'd0);
        chk("rst_pc", 64'(f_o_pc), 64'd0);
        d_rst = 1'b0;

        // Dual push then two pops
        set_wb(1'b1, 3, 5, 0, 1'b1, 4, 7, 4);
        step();
        clr_wb();
        chk("dual_count", 64'(f_o_count), 64'd2);
        chk("dual_rd", 64'(f_o_rd), 64'd3);
        chk("dual_data", 64'(f_o_data), 64'd5);
        chk("dual_pc", 64'(f_o_pc), 64'd0);
        f_i_ready = 1'b1;
        step();
        chk("pop1_rd", 64'(f_o_rd), 64'd4);
        chk("pop1_data", 64'(f_o_data), 64'd7);
        chk("pop1_pc", 64'(f_o_pc), 64'd4);
        chk("pop1_count", 64'(f_o_count), 64'd1);
        step();
        chk("pop2_valid", 64'(f_o_valid), 64'd0);
        chk("pop2_count", 64'(f_o_count), 64'd0);
        chk("pop2_data", 64'(f_o_data), 64'd0);
        step();
        chk("pop_empty_count", 64'(f_o_count), 64'd0);
        f_i_ready = 1'b0;

        // rd=0 filtering
        set_wb(1'b1, 0, 9, 8, 1'b1, 9, 32'h11, 12);
        step();
        clr_wb();
        chk("filt_count", 64'(f_o_count), 64'd1);
        chk("filt_rd", 64'(f_o_rd), 64'd9);
        chk("filt_data", 64'(f_o_data), 64'h11);
        chk("filt_ovf", 64'(f_o_overflow), 64'd0);
        set_wb(1'b1, 0, 9, 16, 1'b0, 0, 0, 0);
        step();
        clr_wb();
        chk("filt1_count", 64'(f_o_count), 64'd1);
        f_i_ready = 1'b1;
        step();
        f_i_ready = 1'b0;
        chk("filt_drain", 64'(f_o_count), 64'd0);

        // Fill to full, drop, drain
        for (int k = 0; k < 4; k++) begin
            set_wb(1'b1, 2*k+1, 100+2*k, 4*k, 1'b1, 2*k+2, 101+2*k, 4*k+2);
            step();
            clr_wb();
            if (k == 2) begin
                chk("fill6_count", 64'(f_o_count), 64'd6);
                chk("fill6_wbrdy", 64'(f_o_wb_ready), 64'd1);
            end
        end
        chk("fill8_count", 64'(f_o_count), 64'd8);
        chk("fill8_wbrdy", 64'(f_o_wb_ready), 64'd0);
        set_wb(1'b1, 0, 55, 0, 1'b0, 0, 0, 0);
        step();
        chk("full_r0_ovf", 64'(f_o_overflow), 64'd0);
        set_wb(1'b1, 7, 77, 0, 1'b0, 0, 0, 0);
        step();
        clr_wb();
        chk("drop_count", 64'(f_o_count), 64'd8);
        chk("drop_ovf", 64'(f_o_overflow), 64'd1);
        f_i_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_data", 64'(f_o_data), 64'(100 + i));
            chk("drain_rd", 64'(f_o_rd), 64'(i + 1));
            step();
        end
        chk("drain_count", 64'(f_o_count), 64'd0);
        chk("drain_ovf", 64'(f_o_overflow), 64'd1);

        // Wrap with concurrent push/pop; pointers start at 3 so the run crosses 7->0
        next_wr = 1;
        next_rd = 1;
        for (int c = 0; c < 11; c++) begin
            pre_cnt = (c == 0) ? 0 : sched_cnt[c-1];
            chk("wrap_valid", 64'(f_o_valid), 64'(pre_cnt != 0));
            if (pre_cnt != 0) begin
                chk("wrap_data", 64'(f_o_data), 64'(next_rd));
                chk("wrap_rd", 64'(f_o_rd), 64'(next_rd));
                chk("wrap_pc", 64'(f_o_pc), 64'(4 * next_rd));
                next_rd++;
            end
            if (sched_push[c] == 2) begin
                set_wb(1'b1, next_wr, next_wr, 4*next_wr, 1'b1, next_wr+1, next_wr+1, 4*(next_wr+1));
                next_wr += 2;
            end else if (sched_push[c] == 1) begin
                set_wb(1'b1, next_wr, next_wr, 4*next_wr, 1'b0, 0, 0, 0);
                next_wr += 1;
            end else begin
                clr_wb();
            end
            step();
            chk("wrap_count", 64'(f_o_count), 64'(sched_cnt[c]));
        end
        clr_wb();
        f_i_ready = 1'b0;

        // Reset mid-operation with push and pop requested
        set_wb(1'b1, 1, 1, 0, 1'b1, 2, 2, 0);
        step();
        set_wb(1'b1, 3, 3, 0, 1'b1, 4, 4, 0);
        step();
        set_wb(1'b0, 0, 0, 0, 1'b1, 5, 5, 0);
        step();
        chk("pre_rst_count", 64'(f_o_count), 64'd5);
        d_rst = 1'b1;
        f_i_ready = 1'b1;
        set_wb(1'b1, 6, 6, 0, 1'b0, 0, 0, 0);
        step();
        chk("mid_rst_count", 64'(f_o_count), 64'd0);
        chk("mid_rst_valid", 64'(f_o_valid), 64'd0);
        chk("mid_rst_ovf", 64'(f_o_overflow), 64'd0);
        d_rst = 1'b0;
        f_i_ready = 1'b0;
        clr_wb();
        step();
        set_wb(1'b1, 6, 32'h66, 24, 1'b0, 0, 0, 0);
        step();
        clr_wb();
        chk("post_rst_count", 64'(f_o_count), 64'd1);
        chk("post_rst_data", 64'(f_o_data), 64'h66);
        chk("post_rst_rd", 64'(f_o_rd), 64'd6);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
